multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_mul_iter.sv | 53 +++++
 rtl/multicycle_alu.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and overflow helpers for the
// multicycle ALU and its decode stage.
package alu_pkg;

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_e;

    // Signed overflow of a+b: operands agree in sign, result disagrees.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow of a-b: operand signs differ, result sign leaves a's.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// WIDTH cycles per product, overflow beyond WIDTH bits discarded.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic [WIDTH-1:0] w_acc_next;

    // The final bit's partial sum is presented directly so the product lands
    // on the same edge that retires the last iteration.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});
    assign done       = r_run && (r_cnt == CNT_W'(WIDTH - 1));
    assign product    = w_acc_next;

    // Iteration state: load on start, then shift-add until the count expires.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= {WIDTH{1'b0}};
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_run    <= 1'b0;
        end else if (start) begin
            r_acc    <= {WIDTH{1'b0}};
            r_mcand  <= a;
            r_mplier <= b;
            r_cnt    <= {CNT_W{1'b0}};
            r_run    <= 1'b1;
        end else if (r_run) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            r_run    <= !done;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle arithmetic/logic ops with NZCV flags plus an
// optional iterative multiply, behind a valid/ready handshake on both sides.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       exe_cmd,
    input  logic             c_in,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             busy
);

    alu_state_e       r_state;
    alu_state_e       w_state_next;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_n, r_z, r_c, r_v;
    logic             r_cin;

    logic             w_accept;
    logic             w_is_mul;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_c, w_v, w_z;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;

    // HOLD marks a stalled result; raising out_ready there still allows a
    // same-cycle drain and accept, exactly as in IDLE.
    assign in_ready = !rst && (((r_state == ST_IDLE) && (!r_out_valid || out_ready)) ||
                               ((r_state == ST_HOLD) && out_ready));
    assign w_accept = in_valid && in_ready;
    assign w_is_mul = (MUL_EN != 0) && (exe_cmd == OP_MUL);

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst     (rst),
                .start   (w_accept && w_is_mul),
                .a       (val1),
                .b       (val2),
                .done    (w_mul_done),
                .product (w_mul_product)
            );
        end else begin : g_no_mul
            assign w_mul_done    = 1'b0;
            assign w_mul_product = {WIDTH{1'b0}};
        end
    endgenerate

    // Single-cycle decode; subtraction is val1 + ~val2 + carry so c is NOT borrow.
    always_comb begin
        w_sum = {(WIDTH + 1){1'b0}};
        w_res = {WIDTH{1'b0}};
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (exe_cmd)
            OP_MOV: begin w_res = val2;        w_c = c_in; end
            OP_MVN: begin w_res = ~val2;       w_c = c_in; end
            OP_AND: begin w_res = val1 & val2; w_c = c_in; end
            OP_ORR: begin w_res = val1 | val2; w_c = c_in; end
            OP_EOR: begin w_res = val1 ^ val2; w_c = c_in; end
            OP_ADD, OP_ADC: begin
                w_sum = {1'b0, val1} + {1'b0, val2} +
                        {{WIDTH{1'b0}}, (exe_cmd == OP_ADC) ? c_in : 1'b0};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = add_ovf(val1[WIDTH-1], val2[WIDTH-1], w_sum[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                w_sum = {1'b0, val1} + {1'b0, ~val2} +
                        {{WIDTH{1'b0}}, (exe_cmd == OP_SBC) ? c_in : 1'b1};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = sub_ovf(val1[WIDTH-1], val2[WIDTH-1], w_sum[WIDTH-1]);
            end
            default: begin
                w_res = {WIDTH{1'b0}};
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
        endcase
        w_z = (w_res == {WIDTH{1'b0}});
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (w_accept && w_is_mul) begin
                    w_state_next = ST_MUL;
                end else if (!w_accept && r_out_valid && !out_ready) begin
                    w_state_next = ST_HOLD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_MUL;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, captured carry and the result/flag output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_n         <= 1'b0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_cin       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cin <= c_in;
            end
            if (w_accept && !w_is_mul) begin
                r_result    <= w_res;
                r_n         <= w_res[WIDTH-1];
                r_z         <= w_z;
                r_c         <= w_c;
                r_v         <= w_v;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end else if ((r_state == ST_MUL) && w_mul_done) begin
                r_result    <= w_mul_product;
                r_n         <= w_mul_product[WIDTH-1];
                r_z         <= (w_mul_product == {WIDTH{1'b0}});
                r_c         <= r_cin;
                r_v         <= 1'b0;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign n         = r_n;
    assign z         = r_z;
    assign c         = r_c;
    assign v         = r_v;
    assign busy      = (r_state == ST_MUL);

endmodule
